// File: rtl/frame_multibuf_if.sv
// Writer/reader bus for frame_multibuf. The buffer is the slave.
// The render engine and the scan-out side together form the master.
interface frame_multibuf_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
);
    logic              en;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] din;
    logic              w_commit;
    logic              w_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              r_acquire;
    logic [DATA_W-1:0] dout;
    logic              r_new;
    logic [7:0]        drop_cnt;

    modport master (
        output en, w_en, w_addr, din, w_commit, r_addr, r_acquire,
        input  w_ready, dout, r_new, drop_cnt
    );

    modport slave (
        input  en, w_en, w_addr, din, w_commit, r_addr, r_acquire,
        output w_ready, dout, r_new, drop_cnt
    );
endinterface

// File: rtl/frame_multibuf.sv
// Ping-pong / triple frame buffer built from single-port read-first RAM banks.
// The writer commits whole frames and the reader acquires the newest one at its frame start.
module frame_multibuf #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit TRIPLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    frame_multibuf_if.slave  bus
);
    localparam int NBANK = TRIPLE ? 3 : 2;

    logic       en;
    logic       commit;
    logic       acquire;
    logic       commit_ok;

    logic [1:0] w_idx_q, w_idx_d;
    logic [1:0] r_idx_q, r_idx_d;
    logic [1:0] p_idx_q, p_idx_d;
    logic       p_full_q, p_full_d;
    logic       w_ready_q, w_ready_d;
    logic       r_new_q, r_new_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] drop_inc;

    // Output bank select trails r_idx by one cycle so that a read issued on
    // the acquire edge still returns the old bank's word.
    logic [1:0] rd_sel_q, rd_sel_d;
    logic       rd_vld_q, rd_vld_d;

    logic [DATA_W-1:0] bank_rdata [4];

    assign en      = bus.en;
    assign commit  = bus.w_commit;
    assign acquire = bus.r_acquire;

    assign drop_inc = (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;

    always_comb begin
        w_idx_d    = w_idx_q;
        r_idx_d    = r_idx_q;
        p_idx_d    = p_idx_q;
        p_full_d   = p_full_q;
        w_ready_d  = w_ready_q;
        r_new_d    = r_new_q;
        drop_cnt_d = drop_cnt_q;
        rd_sel_d   = rd_sel_q;
        rd_vld_d   = rd_vld_q;
        commit_ok  = 1'b0;

        if (en) begin
            rd_sel_d = r_idx_q;
            rd_vld_d = 1'b1;
            if (TRIPLE) begin
                w_ready_d = 1'b1;
                case ({commit, acquire})
                    2'b10: begin
                        w_idx_d  = p_idx_q;
                        p_idx_d  = w_idx_q;
                        p_full_d = 1'b1;
                        if (p_full_q) begin
                            drop_cnt_d = drop_inc;
                        end
                    end
                    2'b01: begin
                        if (p_full_q) begin
                            r_idx_d  = p_idx_q;
                            p_idx_d  = r_idx_q;
                            p_full_d = 1'b0;
                            r_new_d  = 1'b1;
                        end else begin
                            r_new_d  = 1'b0;
                        end
                    end
                    2'b11: begin
                        // Three-way rotation: the reader takes the frame just committed.
                        w_idx_d  = p_idx_q;
                        r_idx_d  = w_idx_q;
                        p_idx_d  = r_idx_q;
                        p_full_d = 1'b0;
                        r_new_d  = 1'b1;
                        if (p_full_q) begin
                            drop_cnt_d = drop_inc;
                        end
                    end
                    default: begin
                    end
                endcase
            end else begin
                commit_ok = commit & w_ready_q;
                if (acquire && (p_full_q || commit_ok)) begin
                    w_idx_d   = r_idx_q;
                    r_idx_d   = w_idx_q;
                    p_full_d  = 1'b0;
                    w_ready_d = 1'b1;
                    r_new_d   = 1'b1;
                end else begin
                    if (acquire) begin
                        r_new_d = 1'b0;
                    end
                    if (commit_ok) begin
                        p_full_d  = 1'b1;
                        w_ready_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_idx_q    <= 2'd0;
            r_idx_q    <= 2'd1;
            p_idx_q    <= 2'd2;
            p_full_q   <= 1'b0;
            w_ready_q  <= 1'b1;
            r_new_q    <= 1'b0;
            drop_cnt_q <= 8'd0;
            rd_sel_q   <= 2'd1;
            rd_vld_q   <= 1'b0;
        end else begin
            w_idx_q    <= w_idx_d;
            r_idx_q    <= r_idx_d;
            p_idx_q    <= p_idx_d;
            p_full_q   <= p_full_d;
            w_ready_q  <= w_ready_d;
            r_new_q    <= r_new_d;
            drop_cnt_q <= drop_cnt_d;
            rd_sel_q   <= rd_sel_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    // Each bank is one single-port RAM whose address follows its current role.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        if (gi < NBANK) begin : g_ram
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] rdata_q;
            logic              is_wr;
            logic              we;
            logic [ADDR_W-1:0] addr;

            always_comb begin
                is_wr = (w_idx_q == 2'(gi));
                addr  = is_wr ? bus.w_addr : bus.r_addr;
                we    = is_wr & bus.w_en & w_ready_q & en & ~rst;
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        mem[addr] <= bus.din;
                    end
                    rdata_q <= mem[addr];
                end
            end

            assign bank_rdata[gi] = rdata_q;
        end else begin : g_none
            assign bank_rdata[gi] = '0;
        end
    end

    // The RAM output register has no reset, so dout is forced to zero until
    // the first enabled read after reset.
    assign bus.dout     = rd_vld_q ? bank_rdata[rd_sel_q] : '0;
    assign bus.w_ready  = w_ready_q;
    assign bus.r_new    = r_new_q;
    assign bus.drop_cnt = drop_cnt_q;

    a_wr_distinct: assert property (@(posedge clk) disable iff (rst) w_idx_q != r_idx_q);
    a_idx_range:   assert property (@(posedge clk) disable iff (rst)
                                    (32'(w_idx_q) < NBANK) && (32'(r_idx_q) < NBANK));

    if (TRIPLE) begin : g_triple_chk
        a_p_distinct: assert property (@(posedge clk) disable iff (rst)
                                       (p_idx_q != w_idx_q) && (p_idx_q != r_idx_q));
    end
endmodule

// File: tb/tb_frame_multibuf.sv
// Scoreboard bench for frame_multibuf: one triple-buffer and one ping-pong instance.
// Stimulus queues expected responses and a negedge monitor pops and compares them.
module tb_frame_multibuf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_multibuf_if #(.DATA_W(12), .ADDR_W(10)) ifa ();
    frame_multibuf_if #(.DATA_W(12), .ADDR_W(6))  ifb ();

    frame_multibuf #(.DATA_W(12), .DEPTH(1024), .TRIPLE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    frame_multibuf #(.DATA_W(12), .DEPTH(64), .TRIPLE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    typedef struct {
        int          id;
        logic [11:0] data;
    } rd_exp_t;

    typedef struct {
        int          id;
        logic        w_ready;
        logic        r_new;
        logic [7:0]  drop;
        logic        chk_dout;
        logic [11:0] dout;
    } st_exp_t;

    rd_exp_t rd_q_a[$];
    rd_exp_t rd_q_b[$];
    st_exp_t st_q_a[$];
    st_exp_t st_q_b[$];

    logic rd_req_a, rd_req_b;
    logic rd_cap_a, rd_cap_b;
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    rd_exp_t re;
    st_exp_t se;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s #%0d: got %0h, required %0h", nm, id, act, req);
        end else begin
            $display("ok   %s #%0d: %0h", nm, id, act);
        end
    endtask

    // A read is answered after the edge that sampled it.
    always @(posedge clk) begin
        rd_cap_a <= rd_req_a & ifa.en & ~rst;
        rd_cap_b <= rd_req_b & ifb.en & ~rst;
    end

    always @(negedge clk) begin
        if (rd_cap_a === 1'b1) begin
            if (rd_q_a.size() == 0) begin
                chk("A_read_unqueued", -1, 32'(ifa.dout), 32'hFFFF_FFFF);
            end else begin
                re = rd_q_a.pop_front();
                chk("A_dout", re.id, 32'(ifa.dout), 32'(re.data));
            end
        end
        if (rd_cap_b === 1'b1) begin
            if (rd_q_b.size() == 0) begin
                chk("B_read_unqueued", -1, 32'(ifb.dout), 32'hFFFF_FFFF);
            end else begin
                re = rd_q_b.pop_front();
                chk("B_dout", re.id, 32'(ifb.dout), 32'(re.data));
            end
        end
        while (st_q_a.size() > 0) begin
            se = st_q_a.pop_front();
            chk("A_w_ready", se.id, 32'(ifa.w_ready), 32'(se.w_ready));
            chk("A_r_new", se.id, 32'(ifa.r_new), 32'(se.r_new));
            chk("A_drop_cnt", se.id, 32'(ifa.drop_cnt), 32'(se.drop));
            if (se.chk_dout) chk("A_dout_hold", se.id, 32'(ifa.dout), 32'(se.dout));
        end
        while (st_q_b.size() > 0) begin
            se = st_q_b.pop_front();
            chk("B_w_ready", se.id, 32'(ifb.w_ready), 32'(se.w_ready));
            chk("B_r_new", se.id, 32'(ifb.r_new), 32'(se.r_new));
            chk("B_drop_cnt", se.id, 32'(ifb.drop_cnt), 32'(se.drop));
            if (se.chk_dout) chk("B_dout_hold", se.id, 32'(ifb.dout), 32'(se.dout));
        end
    end

    task automatic clr_pulses();
        ifa.w_en = 1'b0; ifa.w_commit = 1'b0; ifa.r_acquire = 1'b0; rd_req_a = 1'b0;
        ifb.w_en = 1'b0; ifb.w_commit = 1'b0; ifb.r_acquire = 1'b0; rd_req_b = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr_pulses();
    endtask

    task automatic put_word(input bit b, input int addr, input int data);
        if (!b) begin
            ifa.w_en = 1'b1; ifa.w_addr = 10'(addr); ifa.din = 12'(data);
        end else begin
            ifb.w_en = 1'b1; ifb.w_addr = 6'(addr); ifb.din = 12'(data);
        end
    endtask

    task automatic set_commit(input bit b);
        if (!b) ifa.w_commit = 1'b1; else ifb.w_commit = 1'b1;
    endtask

    task automatic set_acquire(input bit b);
        if (!b) ifa.r_acquire = 1'b1; else ifb.r_acquire = 1'b1;
    endtask

    task automatic write_frame(input bit b, input int base, input int n,
                               input bit commit_last, input bit acq_last);
        for (int a = 0; a < n; a++) begin
            put_word(b, a, base + a);
            if (a == n - 1) begin
                if (commit_last) set_commit(b);
                if (acq_last) set_acquire(b);
            end
            cyc();
        end
    endtask

    task automatic commit(input bit b);
        set_commit(b);
        cyc();
    endtask

    task automatic acquire(input bit b);
        set_acquire(b);
        cyc();
    endtask

    task automatic rd(input bit b, input int addr, input int exp_data, input bit acq);
        rd_exp_t e;
        e.id = tag++;
        e.data = 12'(exp_data);
        if (!b) begin
            ifa.r_addr = 10'(addr); rd_req_a = 1'b1; rd_q_a.push_back(e);
        end else begin
            ifb.r_addr = 6'(addr); rd_req_b = 1'b1; rd_q_b.push_back(e);
        end
        if (acq) set_acquire(b);
        cyc();
    endtask

    task automatic st(input bit b, input bit w_ready, input bit r_new, input int drop,
                      input bit chk_dout, input int dout_v);
        st_exp_t e;
        e.id = tag++;
        e.w_ready = w_ready;
        e.r_new = r_new;
        e.drop = 8'(drop);
        e.chk_dout = chk_dout;
        e.dout = 12'(dout_v);
        if (!b) st_q_a.push_back(e); else st_q_b.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        ifa.en = 1'b1; ifa.w_addr = '0; ifa.din = '0; ifa.r_addr = '0;
        ifb.en = 1'b1; ifb.w_addr = '0; ifb.din = '0; ifb.r_addr = '0;
        clr_pulses();
        repeat (2) cyc();
        st(0, 1, 0, 0, 1, 0);
        st(1, 1, 0, 0, 1, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Triple: full frame, commit, acquire
        write_frame(0, 0, 1024, 0, 0);
        commit(0);
        st(0, 1, 0, 0, 0, 0);
        acquire(0);
        st(0, 1, 1, 0, 0, 0);
        rd(0, 5, 5, 0);
        rd(0, 1023, 1023, 0);

        // Three commits without acquire: two dropped, newest wins
        write_frame(0, 'h100, 64, 0, 0);
        commit(0);
        write_frame(0, 'h200, 64, 0, 0);
        commit(0);
        st(0, 1, 1, 1, 0, 0);
        write_frame(0, 'h300, 64, 0, 0);
        commit(0);
        st(0, 1, 1, 2, 0, 0);
        rd(0, 7, 7, 0);
        rd(0, 8, 8, 1);
        rd(0, 9, 'h309, 0);
        rd(0, 10, 'h30A, 0);
        st(0, 1, 1, 2, 0, 0);
        rd(0, 5, 'h305, 1);
        rd(0, 6, 'h306, 0);
        st(0, 1, 0, 2, 0, 0);

        // Simultaneous commit+acquire while a frame is pending
        write_frame(0, 'h400, 64, 0, 0);
        commit(0);
        st(0, 1, 0, 2, 0, 0);
        write_frame(0, 'h500, 64, 1, 1);
        st(0, 1, 1, 3, 0, 0);
        rd(0, 63, 'h53F, 0);
        rd(0, 0, 'h500, 0);

        // Clock enable low: pulses and writes ignored, dout holds
        ifa.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ifa.w_en = 1'b1; ifa.w_addr = 10'd0; ifa.din = 12'hABC;
            ifa.w_commit = 1'b1; ifa.r_acquire = 1'b1; ifa.r_addr = 10'(i + 1);
            cyc();
            if (i == 4) st(0, 1, 1, 3, 1, 'h500);
        end
        ifa.en = 1'b1;
        st(0, 1, 1, 3, 1, 'h500);
        rd(0, 0, 'h500, 0);
        commit(0);
        acquire(0);
        rd(0, 0, 'h400, 0);
        rd(0, 5, 'h405, 0);
        st(0, 1, 1, 3, 0, 0);

        // Drop counter saturation
        for (int i = 0; i < 260; i++) commit(0);
        st(0, 1, 1, 255, 0, 0);
        rd(0, 0, 'h400, 0);
        cyc();

        // Asynchronous reset mid-frame, checked before the next clock edge
        put_word(0, 10, 'h777);
        #1;
        rst = 1'b1;
        st(0, 1, 0, 0, 1, 0);
        st(1, 1, 0, 0, 1, 0);
        cyc();
        rst = 1'b0;
        cyc();
        rd(0, 5, 'h405, 0);

        // Ping-pong: commit stalls the writer until the reader swaps
        write_frame(1, 'h100, 64, 0, 0);
        commit(1);
        st(1, 0, 0, 0, 0, 0);
        write_frame(1, 'hF00, 64, 0, 0);
        commit(1);
        st(1, 0, 0, 0, 0, 0);
        acquire(1);
        st(1, 1, 1, 0, 0, 0);
        rd(1, 0, 'h100, 0);
        rd(1, 5, 'h105, 0);
        rd(1, 63, 'h13F, 0);
        acquire(1);
        st(1, 1, 0, 0, 0, 0);
        rd(1, 5, 'h105, 0);
        write_frame(1, 'h200, 64, 1, 1);
        st(1, 1, 1, 0, 0, 0);
        rd(1, 63, 'h23F, 0);
        rd(1, 0, 'h200, 0);

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
